// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 window datapath: pixel handshake, shift gating, row/col tracking.
// Optional framing-error detection (sticky oerr, isof restart mid-frame) is enabled by defining FRAME_ERR_EN.
module window_scan_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             isof,
  input  logic             ivalid,
  output logic             oready,
  output logic             oclken,
  output logic             obuf_clr,
  output logic             owin_valid,
  input  logic             idn_ready,
  output logic [COL_W-1:0] ocx,
  output logic [ROW_W-1:0] ocy,
  output logic             oeof,
  output logic             obusy
`ifdef FRAME_ERR_EN
  ,
  output logic             oerr
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             restart;
  logic             col_last;
  logic             row_last;
  logic             win_load;

  // A held window blocks new pixels unless it is being consumed this same cycle.
  assign oready   = (state == RUN) && (!owin_valid || idn_ready);
  assign accept   = ivalid && oready;
  assign oclken   = accept;

`ifdef FRAME_ERR_EN
  assign restart  = isof && !irst;
`else
  assign restart  = isof && !irst && (state == IDLE);
`endif

  assign obuf_clr = irst || restart;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign win_load = accept && (col >= COL_W'(2)) && (row >= ROW_W'(2));

  always_ff @(posedge iclk) begin
    if (irst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      owin_valid <= 1'b0;
      ocx        <= '0;
      ocy        <= '0;
      oeof       <= 1'b0;
      obusy      <= 1'b0;
`ifdef FRAME_ERR_EN
      oerr       <= 1'b0;
`endif
    end else begin
      oeof <= 1'b0;
`ifdef FRAME_ERR_EN
      if ((state == IDLE) && ivalid)
        oerr <= 1'b1;
      if (restart && (state != IDLE))
        oerr <= 1'b1;
`endif
      if (restart) begin
        state      <= RUN;
        obusy      <= 1'b1;
        col        <= '0;
        row        <= '0;
        owin_valid <= 1'b0;
      end else begin
        // Loading a fresh window takes priority over the consume-clear.
        if (win_load) begin
          owin_valid <= 1'b1;
          ocx        <= col - 1'b1;
          ocy        <= row - 1'b1;
        end else if (idn_ready) begin
          owin_valid <= 1'b0;
        end

        case (state)
          RUN: begin
            if (accept) begin
              if (col_last) begin
                col <= '0;
                if (row_last) begin
                  row   <= '0;
                  state <= DRAIN;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (!owin_valid || idn_ready) begin
              oeof  <= 1'b1;
              obusy <= 1'b0;
              state <= IDLE;
            end
          end
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl (IMG_W=5, IMG_H=4): pixel-index reference model plus raster list of expected centres.
// Define FRAME_ERR_EN for both files to exercise the framing-error feature.
module tb_window_scan_ctrl;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          iclk = 1'b0;
  logic          irst;
  logic          isof;
  logic          ivalid;
  logic          idn_ready;
  logic          oready;
  logic          oclken;
  logic          obuf_clr;
  logic          owin_valid;
  logic [CW-1:0] ocx;
  logic [RW-1:0] ocy;
  logic          oeof;
  logic          obusy;
`ifdef FRAME_ERR_EN
  logic          oerr;
`endif

  window_scan_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .iclk       (iclk),
    .irst       (irst),
    .isof       (isof),
    .ivalid     (ivalid),
    .oready     (oready),
    .oclken     (oclken),
    .obuf_clr   (obuf_clr),
    .owin_valid (owin_valid),
    .idn_ready  (idn_ready),
    .ocx        (ocx),
    .ocy        (ocy),
    .oeof       (oeof),
    .obusy      (obusy)
`ifdef FRAME_ERR_EN
    ,
    .oerr       (oerr)
`endif
  );

  always #5 iclk = ~iclk;

  int passed = 0;
  int total  = 0;

  // Reference model: frame progress is just the count of accepted pixels.
  bit m_run, m_drain, m_wv, m_eof, m_err;
  int m_n, m_wx, m_wy;
  int exp_q[$];
  int n_win, n_eof, n_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_drain = 0; m_wv = 0; m_eof = 0; m_err = 0; m_n = 0;
  endtask

  task automatic fill_windows();
    exp_q.delete();
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++)
        exp_q.push_back(r * 16 + c);
  endtask

  task automatic step(input bit rst, input bit sof, input bit vld, input bit dn);
    bit sof_take, exp_rdy, acc, cons, eofn;
    int r, c, e;
    @(negedge iclk);
    irst = rst; isof = sof; ivalid = vld; idn_ready = dn;
    #1;
`ifdef FRAME_ERR_EN
    sof_take = !irst && isof;
`else
    sof_take = !irst && isof && !m_run && !m_drain;
`endif
    exp_rdy = m_run && (!m_wv || idn_ready);
    acc     = ivalid && exp_rdy;
    cons    = m_wv && idn_ready;
    chk("oready", oready, exp_rdy);
    chk("oclken", oclken, acc);
    chk("obuf_clr", obuf_clr, irst || sof_take);
    chk("owin_valid", owin_valid, m_wv);
    chk("oeof", oeof, m_eof);
    chk("obusy", obusy, m_run || m_drain);
`ifdef FRAME_ERR_EN
    chk("oerr", oerr, m_err);
`endif
    if (m_wv) begin
      chk("ocx", ocx, m_wx);
      chk("ocy", ocy, m_wy);
    end
    if (cons && !irst) begin
      n_win++;
      if (exp_q.size() == 0) chk("win_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("win_order", int'(ocy) * 16 + int'(ocx), e);
      end
    end
    if (oclken) n_clk++;
    if (oeof) n_eof++;
    @(posedge iclk);
    if (irst) model_reset();
    else begin
      eofn = m_drain && (!m_wv || idn_ready);
`ifdef FRAME_ERR_EN
      if ((ivalid && !m_run && !m_drain) || (isof && (m_run || m_drain))) m_err = 1;
`endif
      if (sof_take) begin
        m_run = 1; m_drain = 0; m_n = 0; m_wv = 0; eofn = 0;
        fill_windows();
      end else begin
        if (acc) begin
          r = m_n / W; c = m_n % W; m_n++;
          if (r >= 2 && c >= 2) begin m_wv = 1; m_wx = c - 1; m_wy = r - 1; end
          else if (cons) m_wv = 0;
          if (m_n == W * H) begin m_run = 0; m_drain = 1; end
        end else if (cons) m_wv = 0;
        if (eofn) m_drain = 0;
      end
      m_eof = eofn;
    end
    #1;
  endtask

  // isof, then pixels until stop_at accepted (or full frame drained).
  task automatic frame(input bit gappy, input bit bp, input int stop_at);
    int guard, base;
    bit bp_done, v;
    guard = 0; bp_done = 0;
    step(0, 1, 0, 1);
    while (m_run && m_n < stop_at && guard < 500) begin
      if (bp && m_wv && !bp_done) begin
        base = n_clk;
        repeat (5) step(0, 0, 1, 0);
        chk("bp_no_shift", n_clk, base);
        chk("bp_hold_valid", owin_valid, 1);
        chk("bp_hold_ocx", ocx, 1);
        chk("bp_hold_ocy", ocy, 1);
        step(0, 0, 1, 1);
        chk("bp_release_accept", n_clk, base + 1);
        bp_done = 1;
      end else begin
        v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
        step(0, 0, v, 1);
      end
      guard++;
    end
    if (guard >= 500) chk("frame_timeout", 0, 1);
    if (stop_at >= W * H) begin
      guard = 0;
      while ((m_drain || m_eof) && guard < 20) begin
        step(0, 0, 0, 1);
        guard++;
      end
      if (guard >= 20) chk("drain_timeout", 0, 1);
    end
  endtask

  task automatic frame_totals(input string tag, input int w0, input int e0, input int k0);
    chk({tag, "_windows"}, n_win - w0, (W - 2) * (H - 2));
    chk({tag, "_eof"}, n_eof - e0, 1);
    chk({tag, "_clken"}, n_clk - k0, W * H);
    chk({tag, "_idle"}, obusy, 0);
  endtask

  initial begin
    int w0, e0, k0;
    irst = 1; isof = 0; ivalid = 0; idn_ready = 0;
    model_reset();
    n_win = 0; n_eof = 0; n_clk = 0;
    @(posedge iclk);
    #1;

    repeat (3) step(1, 0, 0, 0);
    chk("rst_obuf_clr", obuf_clr, 1);
    chk("rst_oready", oready, 0);
    chk("rst_owin_valid", owin_valid, 0);
    chk("rst_ocx", ocx, 0);
    chk("rst_ocy", ocy, 0);
    chk("rst_oeof", oeof, 0);
    chk("rst_obusy", obusy, 0);
    step(0, 0, 0, 1);

    w0 = n_win; e0 = n_eof; k0 = n_clk;
    frame(0, 0, 1000);
    repeat (2) step(0, 0, 0, 1);
    frame_totals("full", w0, e0, k0);

    w0 = n_win; e0 = n_eof; k0 = n_clk;
    frame(0, 1, 1000);
    repeat (2) step(0, 0, 0, 1);
    frame_totals("bp", w0, e0, k0);

    w0 = n_win; e0 = n_eof; k0 = n_clk;
    frame(1, 0, 1000);
    repeat (2) step(0, 0, 0, 1);
    frame_totals("gappy", w0, e0, k0);

    w0 = n_win; e0 = n_eof; k0 = n_clk;
    frame(0, 0, 9);
    step(1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("abort_no_eof", n_eof - e0, 0);
    chk("abort_idle", obusy, 0);
    chk("abort_pixels", n_clk - k0, 9);
    w0 = n_win; e0 = n_eof; k0 = n_clk;
    frame(0, 0, 1000);
    repeat (2) step(0, 0, 0, 1);
    frame_totals("after_abort", w0, e0, k0);

`ifdef FRAME_ERR_EN
    w0 = n_win; e0 = n_eof;
    frame(0, 0, 7);
    k0 = n_clk;
    frame(0, 0, 1000);
    repeat (2) step(0, 0, 0, 1);
    chk("ferr_oerr", oerr, 1);
    chk("ferr_windows", n_win - w0, (W - 2) * (H - 2));
    chk("ferr_eof", n_eof - e0, 1);
    chk("ferr_clken", n_clk - k0, W * H);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
